// File: rtl/fetch_unit.sv
// Instruction fetch: drives imemAddress, queues {pc, instr} in a prefetch FIFO, hands off to decode.
// Latency 1 cycle (address -> FIFO head); stalls when FIFO full without pop; redirect flushes.
// Optional misaligned-redirect fault state enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imemAddress,
    input  logic [31:0] imemData,
    input  logic        imemValid,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outInstr,
    output logic [31:0] outPc,
    output logic        outFault
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_pc, w_pc_nxt;
    logic [31:0]   r_ent_pc    [FIFO_DEPTH];
    logic [31:0]   r_ent_instr [FIFO_DEPTH];
    logic [PW-1:0] r_rd, r_wr;
    logic [PW:0]   r_count;
    logic          w_pop, w_push;

    assign imemAddress = r_pc;
    assign outValid    = (r_count != '0);
    assign outInstr    = outValid ? r_ent_instr[r_rd] : NOP;
    assign outPc       = outValid ? r_ent_pc[r_rd]    : 32'h0;

    assign w_pop  = outValid & outReady;
    assign w_push = (r_state == ST_RUN) & imemValid & ~redirectValid
                  & ((r_count < DEPTH_C) | w_pop);

`ifdef FETCH_ALIGN_CHECK_EN
    assign outFault = (r_state == ST_FAULT);
`else
    assign outFault = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (redirectValid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            // Misaligned target is kept verbatim so the trap handler can see it.
            w_pc_nxt    = redirectTarget;
            w_state_nxt = (redirectTarget[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
`else
            w_pc_nxt    = {redirectTarget[31:2], 2'b00};
            w_state_nxt = ST_RUN;
`endif
        end else if (w_push) begin
            w_pc_nxt = r_pc + 32'd4;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Redirect wins over push and pop: the head is discarded, not consumed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (redirectValid) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_ent_pc[r_wr]    <= r_pc;
            r_ent_instr[r_wr] <= imemData;
        end
    end

endmodule
